// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature encoder synchroniser, glitch filter, step decoder and position counter
module quad_step_decoder #(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             step_valid,
    output logic             step_dir,
    output logic             overflow,
    output logic             underflow,
    output logic             error
);

    localparam logic [3:0]       FLEN = 4'(FILTER_LEN);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Bit 1 carries channel A, bit 0 carries channel B throughout.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      sync_fill;
    logic [1:0]      pending;
    logic [1:0][3:0] flt_cnt;
    logic [1:0]      filt;
    logic [1:0]      prev;
    logic            primed;

    logic [1:0] cur;
    logic       changed;
    logic       illegal;
    logic       legal;
    logic       dir;
    logic       both_stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 2'b00;
            sync2     <= 2'b00;
            sync_fill <= 2'b00;
            pending   <= 2'b00;
            flt_cnt   <= '0;
            filt      <= 2'b00;
        end else begin
            sync1     <= {quad_a, quad_b};
            sync2     <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
            // Stale reset values in the synchroniser must not count as stable samples.
            if (sync_fill[1]) begin
                for (int i = 0; i < 2; i++) begin
                    if (flt_cnt[i] == 4'd0 || sync2[i] != pending[i]) begin
                        pending[i] <= sync2[i];
                        flt_cnt[i] <= 4'd1;
                    end else if (flt_cnt[i] != FLEN) begin
                        flt_cnt[i] <= flt_cnt[i] + 4'd1;
                    end
                    if (flt_cnt[i] == FLEN) begin
                        filt[i] <= pending[i];
                    end
                end
            end
        end
    end

    always_comb begin
        cur         = filt;
        changed     = primed && (cur != prev);
        illegal     = changed && (cur == ~prev);
        legal       = changed && !illegal;
        // Up steps satisfy A_prev != B_cur for every edge of the Gray cycle.
        dir         = prev[1] ^ cur[0];
        both_stable = (flt_cnt[1] == FLEN) && (flt_cnt[0] == FLEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= 2'b00;
            primed     <= 1'b0;
            count      <= '0;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            error      <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            error      <= illegal;
            // Prime from the value the filters are loading now, so the first real change is the first event.
            if (!primed) begin
                if (both_stable) begin
                    prev   <= pending;
                    primed <= 1'b1;
                end
            end else if (changed) begin
                prev <= cur;
            end
            if (clear) begin
                count <= '0;
            end else if (enable && legal) begin
                step_valid <= 1'b1;
                step_dir   <= dir;
                if (dir) begin
                    count    <= count + ONE;
                    overflow <= &count;
                end else begin
                    count     <= count - ONE;
                    underflow <= (count == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - directed table-driven bench for quad_step_decoder
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       quad_a;
    logic       quad_b;
    logic       enable;
    logic       clear;
    logic [7:0] count;
    logic       step_valid;
    logic       step_dir;
    logic       overflow;
    logic       underflow;
    logic       error;

    int checks = 0;
    int errors = 0;

    quad_step_decoder #(.WIDTH(8), .FILTER_LEN(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .quad_a     (quad_a),
        .quad_b     (quad_b),
        .enable     (enable),
        .clear      (clear),
        .count      (count),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .overflow   (overflow),
        .underflow  (underflow),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       en;
        int         steps;
        int         errs;
        int         ovf;
        int         unf;
        logic       dir;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic a, logic b, logic en, int steps, int errs,
                                int ovf, int unf, logic dir, logic [7:0] cnt);
        vec_t v;
        v.a = a; v.b = b; v.en = en; v.steps = steps; v.errs = errs;
        v.ovf = ovf; v.unf = unf; v.dir = dir; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse counts over n cycles, sampled on the falling edge; first_sv is the 1-based cycle of the first step.
    task automatic run(input int n, output int sv, output int er, output int ov,
                       output int un, output int first_sv);
        sv = 0; er = 0; ov = 0; un = 0; first_sv = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (step_valid) begin
                sv++;
                if (first_sv == 0) first_sv = i;
            end
            er += int'(error);
            ov += int'(overflow);
            un += int'(underflow);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_step_valid"}, int'(step_valid), 0);
        check({tag, "_step_dir"}, int'(step_dir), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_underflow"}, int'(underflow), 0);
        check({tag, "_error"}, int'(error), 0);
    endtask

    initial begin
        int sv, er, ov, un, first;

        vecs[0]  = mk(1, 0, 1, 1, 0, 0, 1, 0, 8'd255);
        vecs[1]  = mk(0, 0, 1, 1, 0, 1, 0, 1, 8'd0);
        vecs[2]  = mk(0, 1, 1, 1, 0, 0, 0, 1, 8'd1);
        vecs[3]  = mk(1, 1, 1, 1, 0, 0, 0, 1, 8'd2);
        vecs[4]  = mk(1, 0, 1, 1, 0, 0, 0, 1, 8'd3);
        vecs[5]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 8'd4);
        vecs[6]  = mk(1, 1, 1, 0, 1, 0, 0, 1, 8'd4);
        vecs[7]  = mk(1, 0, 1, 1, 0, 0, 0, 1, 8'd5);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'd5);
        vecs[9]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 8'd5);
        vecs[10] = mk(1, 1, 0, 0, 0, 0, 0, 1, 8'd5);
        vecs[11] = mk(0, 1, 1, 1, 0, 0, 0, 0, 8'd4);
        vecs[12] = mk(0, 0, 1, 1, 0, 0, 0, 0, 8'd3);
        vecs[13] = mk(0, 1, 1, 1, 0, 0, 0, 1, 8'd4);
        vecs[14] = mk(0, 0, 1, 1, 0, 0, 0, 0, 8'd3);
        vecs[15] = mk(0, 1, 1, 1, 0, 0, 0, 1, 8'd4);
        vecs[16] = mk(1, 1, 1, 1, 0, 0, 0, 1, 8'd5);
        vecs[17] = mk(1, 0, 1, 1, 0, 0, 0, 1, 8'd6);
        vecs[18] = mk(0, 0, 1, 1, 0, 0, 0, 1, 8'd7);

        // Reset and prime with both pins high.
        reset = 1'b1; quad_a = 1'b1; quad_b = 1'b1; enable = 1'b1; clear = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        run(20, sv, er, ov, un, first);
        check("prime11_steps", sv, 0);
        check("prime11_errors", er, 0);
        check("prime11_count", int'(count), 0);

        // Reset again with pins at 00 for the table.
        reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run(20, sv, er, ov, un, first);
        check("prime00_steps", sv, 0);
        check("prime00_errors", er, 0);

        for (int i = 0; i < 19; i++) begin
            quad_a = vecs[i].a; quad_b = vecs[i].b; enable = vecs[i].en;
            run(8, sv, er, ov, un, first);
            check($sformatf("v%0d_steps", i), sv, vecs[i].steps);
            check($sformatf("v%0d_errors", i), er, vecs[i].errs);
            check($sformatf("v%0d_overflow", i), ov, vecs[i].ovf);
            check($sformatf("v%0d_underflow", i), un, vecs[i].unf);
            check($sformatf("v%0d_count", i), int'(count), int'(vecs[i].cnt));
            check($sformatf("v%0d_dir", i), int'(step_dir), int'(vecs[i].dir));
            if (vecs[i].steps == 1) check($sformatf("v%0d_latency", i), first, 7);
        end

        // Two-cycle glitch on A never reaches the filtered value.
        quad_a = 1'b1;
        repeat (2) @(negedge clk);
        quad_a = 1'b0;
        run(12, sv, er, ov, un, first);
        check("glitch_steps", sv, 0);
        check("glitch_errors", er, 0);
        check("glitch_count", int'(count), 7);

        // Clear coincides with the decode cycle of an up step at count 7.
        quad_b = 1'b1;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_step_valid", int'(step_valid), 0);
        check("clear_count", int'(count), 0);
        run(4, sv, er, ov, un, first);
        check("clear_after_steps", sv, 0);
        quad_a = 1'b1;
        run(8, sv, er, ov, un, first);
        check("post_clear_steps", sv, 1);
        check("post_clear_count", int'(count), 1);
        check("post_clear_latency", first, 7);

        // Reset lands one cycle before a step would have been reported.
        quad_b = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("mid_reset");
        reset = 1'b0;
        run(20, sv, er, ov, un, first);
        check("reprime_steps", sv, 0);
        check("reprime_errors", er, 0);
        check("reprime_count", int'(count), 0);
        quad_a = 1'b0;
        run(8, sv, er, ov, un, first);
        check("reprime_up_steps", sv, 1);
        check("reprime_up_count", int'(count), 1);
        check("reprime_up_dir", int'(step_dir), 1);
        check("reprime_up_errors", er, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
Front end that drives counter command strobes from a 2-channel quadrature encoder.
- Synchronises and glitch-filters the A/B pins, then decodes Gray-code transitions into step and direction strobes.
- Keeps a wrapping position count with one-cycle overflow/underflow pulses and an illegal-transition error pulse.
- Sits between the board pins and the position/counter logic, and supplies the enable and up/down pair that logic consumes.

Parameters:
- WIDTH, 8, position counter width in bits; maximum count is 2^WIDTH-1.
- FILTER_LEN, 3, consecutive identical synchronised samples required before a channel's filtered value changes; legal range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- quad_a  input  1  asynchronous encoder channel A.
- quad_b  input  1  asynchronous encoder channel B.
- enable  input  1  when high, decoded steps update count and the step/flag outputs.
- clear  input  1  synchronous count clear.
- count  output  WIDTH  registered position.
- step_valid  output  1  one-cycle pulse per accepted step.
- step_dir  output  1  direction of the last accepted step; 1 = up.
- overflow  output  1  one-cycle pulse when count wraps from max to 0.
- underflow  output  1  one-cycle pulse when count wraps from 0 to max.
- error  output  1  one-cycle pulse on an illegal two-bit transition.

Behaviour:
- Reset: count=0, step_valid=0, step_dir=0, overflow=0, underflow=0, error=0.
  - Synchroniser flops, filter counters, filtered A/B and prev state are all cleared.
  - primed flag cleared.
- Synchroniser: two flops per channel. No logic between the two flops.
- Filter, per channel:
  - Counter increments while the synchronised sample equals the pending value; it restarts at 1 when the sample changes.
  - Filtered value takes the sample in the cycle the counter reaches FILTER_LEN.
  - A glitch shorter than FILTER_LEN cycles never reaches the filtered value.
- Priming:
  - After reset, the first cycle in which both channels have been stable for FILTER_LEN cycles loads prev={A,B} and sets primed.
  - No step and no error is produced in that cycle.
- Decode, evaluated each cycle with primed=1, cur={A_f,B_f}:
  - Up sequence: 00->01->11->10->00.
  - Down sequence: the reverse of the up sequence.
  - cur==prev: no event.
  - Opposite-bit change (00<->11 or 01<->10): error pulses next cycle; count unchanged.
  - prev is loaded with cur on every change, legal or illegal.
- Latency: an A/B change stable from clock edge k produces step_valid and the updated count at edge k+FILTER_LEN+3.
- Step acceptance with enable=1:
  - step_valid pulses one cycle and step_dir takes the decoded direction.
  - Count up at 2^WIDTH-1 wraps to 0 with overflow=1 in the same cycle as the new count.
  - Count down at 0 wraps to 2^WIDTH-1 with underflow=1 in the same cycle.
  - All other steps change count by exactly ±1, modulo 2^WIDTH.
- enable=0:
  - prev still tracks cur, so there is no backlog.
  - step_valid, overflow and underflow stay 0; count and step_dir hold.
  - error is still reported.
- clear=1:
  - count=0 next cycle.
  - A step decoded in the same cycle is discarded: step_valid, overflow and underflow stay 0.
  - prev still updates.
  - error is unaffected by clear.
- Precedence: reset > clear > step.
- Reset mid-rotation: all state is cleared. The next rotation re-primes, so no spurious step or error is produced from a non-00 pin state.
- Pulse outputs never remain high for more than one cycle per event.
- Events are at most one per cycle, because each filtered channel changes at most once every FILTER_LEN cycles.

Test Plan:
- Priming from non-00 pins: reset with A=1, B=1 held, then release reset and wait 20 cycles -> count=0, error=0, step_valid never asserted.
- Forward steps: FILTER_LEN=3 with count=0; drive 00->01->11->10->00, each state held 8 cycles -> four step_valid pulses, step_dir=1, count=4, each pulse 6 cycles after its pin change.
- Down wrap: count=0; apply one down step (00->10) -> count=255, underflow pulses one cycle, step_dir=0. Then apply one up step -> count=0, overflow pulses one cycle.
- Glitch rejection: A pulses high for 2 cycles with FILTER_LEN=3 -> no step_valid, no error, count unchanged.
- Illegal jump: hold 00, then switch A and B together to 11 -> error pulses once, count unchanged. A following 11->10 transition -> count+1.
- Control precedence:
  - enable=0 during 3 up steps -> count holds.
  - clear asserted in the same cycle as a decoded step at count=7 -> count=0, no step_valid.
  - reset asserted mid-sequence -> all outputs 0 the next cycle.
